// File: rtl/sq_pkg.sv
// Shared sizes and FSM state type for the square-grouping and square-expansion stages.
package sq_pkg;

   localparam int SQ_BOX_IDX = 3;
   localparam int COARSE_W   = SQ_BOX_IDX - 1;
   localparam int FINE_W     = SQ_BOX_IDX;
   localparam int N_CELLS    = 1 << (2 * COARSE_W);
   localparam int DATA_W     = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_LAT,
      S_W0,
      S_W1,
      S_W2,
      S_W3,
      S_DONE
   } sq_state_e;

endpackage

// File: rtl/sqe_split.sv
// Child value for one 2x2 child: either a copy of the coarse value or an exact
// four-way split where the first (x mod 4) children absorb the remainder.
module sqe_split
   import sq_pkg::*;
(
   input  logic [DATA_W-1:0] i_x,
   input  logic [1:0]        i_d,
   input  logic              i_div,
   output logic [DATA_W-1:0] o_y
);

   logic [DATA_W-1:0] w_quarter;
   logic              w_extra;

   assign w_quarter = {2'b00, i_x[DATA_W-1:2]};
   assign w_extra   = (i_d < i_x[1:0]);
   assign o_y       = i_div ? (w_quarter + {{(DATA_W-1){1'b0}}, w_extra}) : i_x;

endmodule

// File: rtl/sqe.sv
// Square expansion: reads each coarse cell once and writes it to its four 2x2
// children, with the next coarse read overlapped into the current cell's writes.
module sqe
   import sq_pkg::*;
#(
   parameter int BOX_IDX = SQ_BOX_IDX
)(
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  div_mode,
   input  logic [DATA_W-1:0]     x,
   output logic [2*BOX_IDX-3:0]  SQ_rd_addr,
   output logic                  wen_sqe,
   output logic [2*BOX_IDX-1:0]  BC_wr_addr,
   output logic [DATA_W-1:0]     y,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            dbg_state
);

   localparam int CW = BOX_IDX - 1;
   localparam logic [2*CW-1:0] K_LAST = {(2*CW){1'b1}};

   sq_state_e          r_state;
   logic [2*CW-1:0]    r_k;
   logic [2*CW-1:0]    r_rd_addr;
   logic [1:0]         r_d;
   logic [DATA_W-1:0]  r_x;
   logic               r_div;
   logic               r_wen;
   logic               r_busy;
   logic               r_done;

   logic [CW-1:0]      w_cx;
   logic [CW-1:0]      w_cy;
   logic [DATA_W-1:0]  w_y;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state   <= S_IDLE;
         r_k       <= '0;
         r_d       <= '0;
         r_x       <= '0;
         r_div     <= 1'b0;
         r_rd_addr <= '0;
         r_wen     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else if (abort) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_d     <= '0;
         r_wen   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_RD;
                  r_busy    <= 1'b1;
                  r_div     <= div_mode;
                  r_k       <= '0;
                  r_d       <= '0;
                  r_rd_addr <= '0;
               end
            end
            S_RD: r_state <= S_LAT;
            S_LAT: begin
               r_state <= S_W0;
               r_x     <= x;
               r_d     <= 2'd0;
               r_wen   <= 1'b1;
            end
            S_W0: begin
               r_state <= S_W1;
               r_d     <= 2'd1;
            end
            // The next cell's read is presented during W2 so its data lands in W3.
            S_W1: begin
               r_state <= S_W2;
               r_d     <= 2'd2;
               if (r_k != K_LAST) r_rd_addr <= r_k + 1'b1;
            end
            S_W2: begin
               r_state <= S_W3;
               r_d     <= 2'd3;
            end
            S_W3: begin
               r_d <= 2'd0;
               if (r_k != K_LAST) begin
                  r_state <= S_W0;
                  r_k     <= r_k + 1'b1;
                  r_x     <= x;
               end else begin
                  r_state <= S_DONE;
                  r_wen   <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_k     <= '0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_cx = r_k[2*CW-1:CW];
   assign w_cy = r_k[CW-1:0];

   sqe_split u_split (
      .i_x   (r_x),
      .i_d   (r_d),
      .i_div (r_div),
      .o_y   (w_y)
   );

   assign SQ_rd_addr = r_rd_addr;
   assign wen_sqe    = r_wen;
   assign BC_wr_addr = r_wen ? {w_cx, r_d[1], w_cy, r_d[0]} : '0;
   assign y          = r_wen ? w_y : '0;
   assign busy       = r_busy;
   assign done       = r_done;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_sqe.sv
// Bench for sqe: a 1-cycle-latency SQ memory model feeds the DUT, and every BC
// write is checked against a child list computed from the cell geometry.
`timescale 1ns/1ps
module tb_sqe;
   import sq_pkg::*;

   localparam int BOX = 3;
   localparam int CS  = 1 << (BOX - 1);
   localparam int FS  = 1 << BOX;
   localparam int NC  = CS * CS;
   localparam int AW  = 2 * BOX - 2;
   localparam int FW  = 2 * BOX;
   localparam int RUN_CYC = 4 * NC + 3;

   // clock / reset block
   logic CLK = 1'b0;
   logic RST_n = 1'b0;
   always #5 CLK = ~CLK;

   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          div_mode = 1'b0;
   logic [7:0]    x;
   logic [7:0]    x_mem;
   logic [7:0]    x_rand = 8'd0;
   logic          mem_en = 1'b0;
   logic [AW-1:0] SQ_rd_addr;
   logic          wen_sqe;
   logic [FW-1:0] BC_wr_addr;
   logic [7:0]    y;
   logic          busy;
   logic          done;
   logic [2:0]    dbg_state;

   sqe #(.BOX_IDX(BOX)) dut (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .start      (start),
      .abort      (abort),
      .div_mode   (div_mode),
      .x          (x),
      .SQ_rd_addr (SQ_rd_addr),
      .wen_sqe    (wen_sqe),
      .BC_wr_addr (BC_wr_addr),
      .y          (y),
      .busy       (busy),
      .done       (done),
      .dbg_state  (dbg_state)
   );

   // SQ buffer model: data appears the cycle after the address is presented
   logic [7:0] sq_mem [NC];
   always @(posedge CLK) x_mem <= sq_mem[SQ_rd_addr];
   assign x = mem_en ? x_mem : x_rand;

   // scoreboard
   logic [FW+7:0] exp_q[$];
   logic [FW+7:0] obs_q[$];
   logic [AW-1:0] rd_q[$];
   int checks = 0;
   int errors = 0;
   int done_cyc, busy_cyc, done_cnt;
   bit timed_out;

   function automatic void build_expected(input bit div);
      exp_q.delete();
      for (int k = 0; k < NC; k++) begin
         for (int d = 0; d < 4; d++) begin
            int cx, cy, v, addr, val;
            cx   = k / CS;
            cy   = k % CS;
            v    = sq_mem[k];
            addr = (2 * cx + d / 2) * FS + (2 * cy + d % 2);
            val  = div ? (v / 4 + ((d < v % 4) ? 1 : 0)) : v;
            exp_q.push_back({FW'(addr), 8'(val)});
         end
      end
   endfunction

   task automatic fill_random();
      for (int k = 0; k < NC; k++) sq_mem[k] = 8'($urandom_range(0, 255));
   endtask

   // driver: start is seen at exactly one edge, div_mode scrambled afterwards
   task automatic do_start(input bit div);
      @(negedge CLK);
      start = 1'b1;
      div_mode = div;
      @(posedge CLK);
      #1;
      start = 1'b0;
      div_mode = 1'($urandom_range(0, 1));
   endtask

   // monitor: cycle 1 is the cycle right after the start edge
   task automatic capture(input int max_cyc);
      int c, nw;
      c = 0;
      nw = 0;
      obs_q.delete();
      rd_q.delete();
      done_cyc = 0;
      busy_cyc = 0;
      done_cnt = 0;
      timed_out = 1'b0;
      while (1) begin
         @(negedge CLK);
         c++;
         if (wen_sqe) begin
            if (nw % 4 == 2) rd_q.push_back(SQ_rd_addr);
            obs_q.push_back({BC_wr_addr, y});
            nw++;
         end
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (!busy && c > 1) break;
         if (c >= max_cyc) begin
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int wen_seen;
      RST_n = 1'b0;
      mem_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         x_rand = 8'($urandom_range(0, 255));
         #1;
         checks++;
         if ({SQ_rd_addr, wen_sqe, BC_wr_addr, y, busy, done} !== '0 || dbg_state !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%0d wen=%0b wr=%0d y=%0d busy=%0b done=%0b st=%0d, expected all 0",
                     SQ_rd_addr, wen_sqe, BC_wr_addr, y, busy, done, dbg_state);
         end
      end
      @(negedge CLK);
      RST_n = 1'b1;
      wen_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         x_rand = 8'($urandom_range(0, 255));
         if (wen_sqe || busy) wen_seen++;
      end
      checks++;
      if (wen_seen !== 0) begin
         errors++;
         $display("FAIL idle_quiet: got %0d active cycles, expected 0", wen_seen);
      end
      mem_en = 1'b1;
   endtask

   task automatic test_replicate();
      for (int k = 0; k < NC; k++) sq_mem[k] = 8'(k + 1);
      build_expected(1'b0);
      do_start(1'b0);
      capture(200);
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL repl_timeout: got no end of run within 200 cycles, expected %0d", RUN_CYC);
      end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL repl_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL repl_write[%0d]: got addr %0d data %0d, expected addr %0d data %0d",
                     i, obs_q[i][FW+7:8], obs_q[i][7:0], exp_q[i][FW+7:8], exp_q[i][7:0]);
         end
      end
      checks++;
      if (done_cyc !== RUN_CYC || done_cnt !== 1) begin
         errors++;
         $display("FAIL repl_done: got done at cycle %0d (%0d pulses), expected cycle %0d (1 pulse)",
                  done_cyc, done_cnt, RUN_CYC);
      end
      checks++;
      if (busy_cyc !== RUN_CYC) begin
         errors++;
         $display("FAIL repl_busy: got %0d busy cycles, expected %0d", busy_cyc, RUN_CYC);
      end
   endtask

   task automatic test_split();
      logic [7:0] want [12];
      want = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd64, 8'd64, 8'd64, 8'd63, 8'd0, 8'd0, 8'd0, 8'd0};
      fill_random();
      sq_mem[0] = 8'd7;
      sq_mem[1] = 8'd255;
      sq_mem[2] = 8'd0;
      build_expected(1'b1);
      do_start(1'b1);
      capture(200);
      checks++;
      if (obs_q.size() !== exp_q.size() || timed_out) begin
         errors++;
         $display("FAIL split_count: got %0d writes (timeout=%0b), expected %0d", obs_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL split_write[%0d]: got addr %0d data %0d, expected addr %0d data %0d",
                     i, obs_q[i][FW+7:8], obs_q[i][7:0], exp_q[i][FW+7:8], exp_q[i][7:0]);
         end
      end
      for (int i = 0; i < 12; i++) begin
         logic [FW+7:0] o;
         o = (i < obs_q.size()) ? obs_q[i] : 'x;
         checks++;
         if (o[7:0] !== want[i]) begin
            errors++;
            $display("FAIL split_child[%0d]: got %0d, expected %0d", i, o[7:0], want[i]);
         end
      end
      for (int k = 0; k < NC && 4 * k + 3 < obs_q.size(); k++) begin
         int s;
         s = 0;
         for (int d = 0; d < 4; d++) s += int'(obs_q[4 * k + d][7:0]);
         checks++;
         if (s !== int'(sq_mem[k])) begin
            errors++;
            $display("FAIL split_sum[%0d]: got %0d, expected %0d", k, s, sq_mem[k]);
         end
      end
   endtask

   task automatic test_pipeline();
      bit div;
      div = 1'($urandom_range(0, 1));
      fill_random();
      build_expected(div);
      do_start(div);
      capture(200);
      checks++;
      if (rd_q.size() !== NC) begin
         errors++;
         $display("FAIL pipe_reads: got %0d W2 samples, expected %0d", rd_q.size(), NC);
      end
      for (int k = 0; k < NC && k < rd_q.size(); k++) begin
         logic [AW-1:0] want_a;
         want_a = (k < NC - 1) ? AW'(k + 1) : AW'(NC - 1);
         checks++;
         if (rd_q[k] !== want_a) begin
            errors++;
            $display("FAIL pipe_addr[%0d]: got SQ_rd_addr %0d in W2, expected %0d", k, rd_q[k], want_a);
         end
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL pipe_write[%0d]: got addr %0d data %0d, expected addr %0d data %0d",
                     i, obs_q[i][FW+7:8], obs_q[i][7:0], exp_q[i][FW+7:8], exp_q[i][7:0]);
         end
      end
   endtask

   task automatic test_abort();
      int nw, c, bad;
      // start and abort together in IDLE: abort wins
      @(negedge CLK);
      start = 1'b1;
      abort = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge CLK);
      checks++;
      if (busy !== 1'b0 || wen_sqe !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got busy=%0b wen=%0b, expected 0 0", busy, wen_sqe);
      end
      fill_random();
      do_start(1'($urandom_range(0, 1)));
      nw = 0;
      c = 0;
      bad = 0;
      while (nw < 20 && c < 100) begin
         @(negedge CLK);
         c++;
         if (wen_sqe) nw++;
         if (done) bad++;
      end
      abort = 1'b1;
      @(posedge CLK);
      #1;
      abort = 1'b0;
      @(negedge CLK);
      checks++;
      if (nw !== 20 || busy !== 1'b0 || wen_sqe !== 1'b0) begin
         errors++;
         $display("FAIL abort_run: got writes=%0d busy=%0b wen=%0b after abort, expected 20 0 0", nw, busy, wen_sqe);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (done || wen_sqe || busy) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL abort_quiet: got %0d done/active cycles, expected 0", bad);
      end
      fill_random();
      build_expected(1'b1);
      do_start(1'b1);
      capture(200);
      checks++;
      if (obs_q !== exp_q || done_cyc !== RUN_CYC || done_cnt !== 1) begin
         errors++;
         $display("FAIL abort_rerun: got %0d writes done at %0d (%0d pulses), expected %0d writes done at %0d",
                  obs_q.size(), done_cyc, done_cnt, exp_q.size(), RUN_CYC);
      end
   endtask

   task automatic test_reset_mid();
      fill_random();
      do_start(1'b0);
      repeat (30) @(negedge CLK);
      RST_n = 1'b0;
      #1;
      checks++;
      if ({SQ_rd_addr, wen_sqe, BC_wr_addr, y, busy, done} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got rd=%0d wen=%0b wr=%0d y=%0d busy=%0b done=%0b, expected all 0",
                  SQ_rd_addr, wen_sqe, BC_wr_addr, y, busy, done);
      end
      @(negedge CLK);
      RST_n = 1'b1;
      fill_random();
      build_expected(1'b0);
      do_start(1'b0);
      capture(200);
      checks++;
      if (obs_q !== exp_q || done_cyc !== RUN_CYC) begin
         errors++;
         $display("FAIL reset_rerun: got %0d writes done at %0d, expected %0d writes done at %0d",
                  obs_q.size(), done_cyc, exp_q.size(), RUN_CYC);
      end
   endtask

   task automatic test_back_to_back();
      int c, busy68, busy69;
      int done_at[$];
      bit div;
      div = 1'($urandom_range(0, 1));
      fill_random();
      build_expected(div);
      for (int i = 0; i < 4 * NC; i++) exp_q.push_back(exp_q[i]);
      obs_q.delete();
      @(negedge CLK);
      start = 1'b1;
      div_mode = div;
      @(posedge CLK);
      #1;
      start = 1'b0;
      c = 0;
      busy68 = -1;
      busy69 = -1;
      while (c < 2 * RUN_CYC + 20) begin
         @(negedge CLK);
         c++;
         if (wen_sqe) obs_q.push_back({BC_wr_addr, y});
         if (done) done_at.push_back(c);
         if (c == RUN_CYC + 1) busy68 = int'(busy);
         if (c == RUN_CYC + 2) busy69 = int'(busy);
         if (c == 10) start = 1'b1;
         else if (c == 11) start = 1'b0;
         else if (c == RUN_CYC - 1) start = 1'b1;
         else if (c == RUN_CYC + 2) start = 1'b0;
      end
      checks++;
      if (done_at.size() !== 2) begin
         errors++;
         $display("FAIL b2b_runs: got %0d done pulses, expected 2", done_at.size());
      end else begin
         checks++;
         if (done_at[0] !== RUN_CYC || done_at[1] !== 2 * RUN_CYC + 1) begin
            errors++;
            $display("FAIL b2b_done: got done at %0d and %0d, expected %0d and %0d",
                     done_at[0], done_at[1], RUN_CYC, 2 * RUN_CYC + 1);
         end
      end
      checks++;
      if (busy68 !== 0 || busy69 !== 1) begin
         errors++;
         $display("FAIL b2b_gap: got busy %0d,%0d after DONE, expected 0,1", busy68, busy69);
      end
      checks++;
      if (obs_q !== exp_q) begin
         errors++;
         $display("FAIL b2b_writes: got %0d writes, expected %0d matching", obs_q.size(), exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_replicate();
      test_split();
      test_pipeline();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
